// File: rtl/aes_pkg.sv
// Shared AES data-path constants and the serializer state type.
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_W      = 8;
  localparam int AES_BLOCK_W     = AES_BLOCK_BYTES * AES_BYTE_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;
endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous block FIFO; read data is registered and updates only on a pop.
module aes_block_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      rdata  <= '0;
    end else begin
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end
endmodule

// File: rtl/aes_ecb_byte_serializer.sv
// Buffers AES ciphertext blocks and streams them out byte 0 first over valid/ready.
module aes_ecb_byte_serializer
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH  = AES_BYTE_W,
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int DEPTH       = 4,
  localparam int BLOCK_W    = DATA_WIDTH * BLOCK_BYTES,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int IDX_W      = $clog2(BLOCK_BYTES)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic [BLOCK_W-1:0]    block_i,
  input  logic                  block_valid_i,
  output logic                  fifo_full_o,
  output logic [ADDR_W:0]       level_o,
  output logic [DATA_WIDTH-1:0] byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  last_o,
  output logic                  overflow_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  ser_state_t         state;
  ser_state_t         state_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [BLOCK_W-1:0] cur_block;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               sending;

  assign push = block_valid_i & enable_i;

  aes_block_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (push),
    .pop   (pop),
    .wdata (block_i),
    .rdata (cur_block),
    .full  (fifo_full_o),
    .empty (fifo_empty),
    .count (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // enable_i only gates loading a new block; a block already in SEND always completes.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    pop          = 1'b0;
    byte_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && enable_i) begin
          pop        = 1'b1;
          idx_next   = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          if (idx == LAST_IDX) begin
            idx_next = '0;
            if (!fifo_empty && enable_i) begin
              pop = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sending = (state == ST_SEND);
  assign byte_o  = sending ? cur_block[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign last_o  = sending && (idx == LAST_IDX);

  // A push is lost only when the FIFO is full and nothing leaves it this cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o <= 1'b0;
    end else if (push && fifo_full_o && !pop) begin
      overflow_o <= 1'b1;
    end
  end
endmodule
